// File: rtl/e203_itcm_icb_reader.sv
// ITCM readback engine: an ICB master that walks a range of 64-bit words,
// folding each into a 32-bit additive checksum and a 64-bit XOR signature.
// One transaction is kept outstanding at a time, which keeps the response
// path trivial and matches the single-beat ITCM ICB protocol.
module e203_itcm_icb_reader #(
    parameter int AW = 16,
    parameter int DW = 64,
    parameter int LW = 14
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [LW-1:0]   len,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [AW-1:0]   err_addr,
    output logic [31:0]     checksum,
    output logic [63:0]     xorsum,
    output logic            icb_cmd_valid,
    input  logic            icb_cmd_ready,
    output logic [AW-1:0]   icb_cmd_addr,
    output logic            icb_cmd_read,
    output logic [DW-1:0]   icb_cmd_wdata,
    output logic [DW/8-1:0] icb_cmd_wmask,
    input  logic            icb_rsp_valid,
    output logic            icb_rsp_ready,
    input  logic [DW-1:0]   icb_rsp_rdata,
    input  logic            icb_rsp_err
);

    typedef enum logic [1:0] {IDLE, CMD, RSP, FIN} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] addr_reg;
    logic [LW-1:0] remain_reg;
    logic          err_reg;
    logic [AW-1:0] err_addr_reg;
    logic [31:0]   csum_reg;
    logic [63:0]   xor_reg;

    logic cmd_hs;
    logic rsp_hs;

    assign cmd_hs = icb_cmd_valid & icb_cmd_ready;
    assign rsp_hs = icb_rsp_valid & icb_rsp_ready;

    // Handshake strobes and status come straight from the state register so
    // an asynchronous reset drops them without waiting for a clock edge.
    assign icb_cmd_valid = (state_reg == CMD);
    assign icb_rsp_ready = (state_reg == RSP);
    assign done          = (state_reg == FIN);
    assign busy          = (state_reg != IDLE);
    assign icb_cmd_addr  = addr_reg;
    assign icb_cmd_read  = 1'b1;
    assign icb_cmd_wdata = '0;
    assign icb_cmd_wmask = '0;
    assign err           = err_reg;
    assign err_addr      = err_addr_reg;
    assign checksum      = csum_reg;
    assign xorsum        = xor_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; an error response or the last word ends the run.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = (len == '0) ? FIN : CMD;
            CMD:  if (cmd_hs) state_next = RSP;
            RSP: begin
                if (rsp_hs) begin
                    if (icb_rsp_err || (remain_reg == LW'(1))) begin
                        state_next = FIN;
                    end else begin
                        state_next = CMD;
                    end
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch the request on start, then fold in each good response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg     <= '0;
            remain_reg   <= '0;
            err_reg      <= 1'b0;
            err_addr_reg <= '0;
            csum_reg     <= '0;
            xor_reg      <= '0;
        end else if (state_reg == IDLE && start) begin
            // Low three bits are forced to zero: reads are word aligned.
            addr_reg     <= base_addr & ~AW'(7);
            remain_reg   <= len;
            err_reg      <= 1'b0;
            err_addr_reg <= '0;
            csum_reg     <= '0;
            xor_reg      <= '0;
        end else if (state_reg == RSP && rsp_hs) begin
            if (icb_rsp_err) begin
                err_reg      <= 1'b1;
                err_addr_reg <= addr_reg;
            end else begin
                csum_reg   <= csum_reg + icb_rsp_rdata[31:0] + icb_rsp_rdata[63:32];
                xor_reg    <= xor_reg ^ icb_rsp_rdata[63:0];
                addr_reg   <= addr_reg + AW'(8);
                remain_reg <= remain_reg - LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_e203_itcm_icb_reader.sv
// Directed bench for the ITCM readback engine: a behavioural ICB slave with
// optional random stalls and error injection, plus a reference fold of the
// same backing memory to produce expected checksums.
module tb_e203_itcm_icb_reader;

    localparam int AW = 16;
    localparam int DW = 64;
    localparam int LW = 14;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic [LW-1:0]   len = '0;
    logic            busy, done, err;
    logic [AW-1:0]   err_addr;
    logic [31:0]     checksum;
    logic [63:0]     xorsum;
    logic            icb_cmd_valid;
    logic            icb_cmd_ready = 1'b0;
    logic [AW-1:0]   icb_cmd_addr;
    logic            icb_cmd_read;
    logic [DW-1:0]   icb_cmd_wdata;
    logic [DW/8-1:0] icb_cmd_wmask;
    logic            icb_rsp_valid = 1'b0;
    logic            icb_rsp_ready;
    logic [DW-1:0]   icb_rsp_rdata = '0;
    logic            icb_rsp_err = 1'b0;

    e203_itcm_icb_reader #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .err(err), .err_addr(err_addr),
        .checksum(checksum), .xorsum(xorsum),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:8191];

    int n_checks = 0;
    int n_fail   = 0;

    // Slave configuration and observation state.
    int            stall_max = 0;
    int            err_idx   = -1;
    int            cmd_cnt   = 0;
    int            rsp_idx   = 0;
    int            viol      = 0;
    logic [AW-1:0] cmd_log [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference fold over the backing memory, stopping at the injected error.
    task automatic model(input logic [AW-1:0] b, input int n, input int ei,
                         output logic [31:0] cs, output logic [63:0] xs);
        logic [AW-1:0] a;
        logic [63:0]   w;
        a  = b & 16'hFFF8;
        cs = '0;
        xs = '0;
        for (int i = 0; i < n; i++) begin
            if (i == ei) break;
            w  = mem[a[AW-1:3]];
            cs = cs + w[31:0] + w[63:32];
            xs = xs ^ w;
            a  = a + 16'd8;
        end
    endtask

    // ICB slave: decides inputs on the falling edge; handshakes seen here
    // take effect at the following rising edge.
    initial begin
        bit            cmd_hs_q, rsp_hs_q, pend, stall_prev;
        logic [AW-1:0] cmd_addr_q, pend_addr, stall_addr;
        int            cmd_wait, rsp_wait;
        cmd_hs_q = 0; rsp_hs_q = 0; pend = 0; stall_prev = 0;
        cmd_addr_q = '0; pend_addr = '0; stall_addr = '0;
        cmd_wait = 0; rsp_wait = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cmd_hs_q = 0; rsp_hs_q = 0; pend = 0; stall_prev = 0;
                cmd_wait = 0; rsp_wait = 0;
                icb_cmd_ready = 1'b0;
                icb_rsp_valid = 1'b0;
                icb_rsp_err   = 1'b0;
            end else begin
                if (rsp_hs_q) begin
                    pend = 0;
                    rsp_idx++;
                end
                if (cmd_hs_q) begin
                    pend = 1;
                    pend_addr = cmd_addr_q;
                end
                if (stall_prev && (!icb_cmd_valid || icb_cmd_addr !== stall_addr)) viol++;
                if (icb_cmd_valid && cmd_wait > 0) begin
                    icb_cmd_ready = 1'b0;
                    cmd_wait--;
                end else begin
                    icb_cmd_ready = 1'b1;
                end
                stall_prev = icb_cmd_valid && !icb_cmd_ready;
                stall_addr = icb_cmd_addr;
                if (pend && rsp_wait > 0) begin
                    icb_rsp_valid = 1'b0;
                    rsp_wait--;
                end else if (pend) begin
                    icb_rsp_valid = 1'b1;
                    icb_rsp_rdata = mem[pend_addr[AW-1:3]];
                    icb_rsp_err   = (rsp_idx == err_idx);
                end else begin
                    icb_rsp_valid = 1'b0;
                    icb_rsp_err   = 1'b0;
                end
                cmd_hs_q = icb_cmd_valid && icb_cmd_ready;
                if (cmd_hs_q) begin
                    cmd_cnt++;
                    cmd_log.push_back(icb_cmd_addr);
                    cmd_addr_q = icb_cmd_addr;
                    cmd_wait = $urandom_range(0, stall_max);
                end
                rsp_hs_q = icb_rsp_valid && icb_rsp_ready;
                if (rsp_hs_q) rsp_wait = $urandom_range(0, stall_max);
            end
        end
    end

    // One readback: returns the number of cycles from the start cycle to done.
    task automatic run(input logic [AW-1:0] b, input logic [LW-1:0] n, input bit poke, output int lat);
        cmd_log.delete();
        cmd_cnt   = 0;
        rsp_idx   = 0;
        base_addr = b;
        len       = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        base_addr = 16'hA5A0;
        len       = 14'h3FFF;
        lat = 1;
        while (!done && lat < 4000) begin
            start = poke && (lat == 2);
            tick();
            lat++;
        end
        start = 1'b0;
        check("done_seen", {63'd0, done}, 64'd1);
        $display("run base=%h len=%0d cycles=%0d cmds=%0d csum=%h xor=%h err=%0d",
                 b, n, lat, cmd_cnt, checksum, xorsum, err);
    endtask

    initial begin
        int          lat, mism;
        logic [31:0] cs;
        logic [63:0] xs;
        logic [AW-1:0] a;

        for (int i = 0; i < 8192; i++) begin
            mem[i] = {32'(i) * 32'h9E3779B9, 32'(i) ^ 32'h5A5A0000};
        end

        // Reset, then idle with no start.
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_err_addr", {48'd0, err_addr}, 64'd0);
        check("rst_checksum", {32'd0, checksum}, 64'd0);
        check("rst_xorsum", xorsum, 64'd0);
        check("rst_cmd_addr", {48'd0, icb_cmd_addr}, 64'd0);
        check("rst_rsp_ready", {63'd0, icb_rsp_ready}, 64'd0);
        check("const_read", {63'd0, icb_cmd_read}, 64'd1);
        check("const_wdata", icb_cmd_wdata, 64'd0);
        check("const_wmask", {56'd0, icb_cmd_wmask}, 64'd0);
        mism = 0;
        for (int i = 0; i < 100; i++) begin
            if (icb_cmd_valid !== 1'b0) mism++;
            tick();
        end
        check("idle_no_cmd", 64'(mism), 64'd0);

        // Basic two-word run with zero-wait memory.
        mem[0] = 64'h0000000200000001;
        mem[1] = 64'h0000000400000003;
        run(16'h0000, 14'd2, 1'b0, lat);
        check("b_latency", 64'(lat), 64'd5);
        check("b_cmd_cnt", 64'(cmd_cnt), 64'd2);
        check("b_addr0", {48'd0, cmd_log[0]}, 64'h0);
        check("b_addr1", {48'd0, cmd_log[1]}, 64'h8);
        check("b_checksum", {32'd0, checksum}, 64'h0000000A);
        check("b_xorsum", xorsum, 64'h0000000600000002);
        check("b_err", {63'd0, err}, 64'd0);
        tick();
        check("b_done_once", {63'd0, done}, 64'd0);
        check("b_busy_after", {63'd0, busy}, 64'd0);
        repeat (3) tick();
        check("b_hold_checksum", {32'd0, checksum}, 64'h0000000A);

        // Unaligned base address.
        run(16'h000D, 14'd1, 1'b0, lat);
        model(16'h000D, 1, -1, cs, xs);
        check("u_cmd_cnt", 64'(cmd_cnt), 64'd1);
        check("u_addr", {48'd0, cmd_log[0]}, 64'h8);
        check("u_checksum", {32'd0, checksum}, {32'd0, cs});
        tick();

        // Zero-length run.
        run(16'h0040, 14'd0, 1'b0, lat);
        check("z_latency", 64'(lat), 64'd1);
        check("z_cmd_cnt", 64'(cmd_cnt), 64'd0);
        check("z_checksum", {32'd0, checksum}, 64'd0);
        check("z_xorsum", xorsum, 64'd0);
        tick();

        // Random stalls on both channels.
        stall_max = 5;
        viol = 0;
        run(16'h0200, 14'd16, 1'b0, lat);
        model(16'h0200, 16, -1, cs, xs);
        check("s_cmd_cnt", 64'(cmd_cnt), 64'd16);
        check("s_stable", 64'(viol), 64'd0);
        check("s_checksum", {32'd0, checksum}, {32'd0, cs});
        check("s_xorsum", xorsum, xs);
        mism = 0;
        a = 16'h0200;
        foreach (cmd_log[i]) begin
            if (cmd_log[i] !== a) mism++;
            a = a + 16'd8;
        end
        check("s_addr_seq", 64'(mism), 64'd0);
        stall_max = 0;
        tick();

        // Error on the third response.
        err_idx = 2;
        run(16'h0100, 14'd4, 1'b0, lat);
        model(16'h0100, 4, 2, cs, xs);
        check("e_err", {63'd0, err}, 64'd1);
        check("e_err_addr", {48'd0, err_addr}, 64'h0110);
        check("e_checksum", {32'd0, checksum}, {32'd0, cs});
        check("e_xorsum", xorsum, xs);
        tick();
        check("e_done_once", {63'd0, done}, 64'd0);
        repeat (5) tick();
        check("e_cmd_cnt", 64'(cmd_cnt), 64'd3);
        check("e_err_hold", {63'd0, err}, 64'd1);
        err_idx = -1;

        // Address wrap at the top of the ITCM.
        run(16'hFFF8, 14'd2, 1'b0, lat);
        model(16'hFFF8, 2, -1, cs, xs);
        check("w_addr1", {48'd0, cmd_log[1]}, 64'h0);
        check("w_checksum", {32'd0, checksum}, {32'd0, cs});
        check("w_err_cleared", {63'd0, err}, 64'd0);
        tick();

        // start while busy and in FIN is ignored.
        run(16'h0300, 14'd3, 1'b1, lat);
        model(16'h0300, 3, -1, cs, xs);
        check("p_latency", 64'(lat), 64'd7);
        check("p_checksum", {32'd0, checksum}, {32'd0, cs});
        check("p_xorsum", xorsum, xs);
        base_addr = 16'h0500;
        len = 14'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("p_fin_start_cnt", 64'(cmd_cnt), 64'd3);
        check("p_fin_start_busy", {63'd0, busy}, 64'd0);

        // Asynchronous reset during a response wait.
        cmd_log.delete();
        cmd_cnt = 0;
        rsp_idx = 0;
        base_addr = 16'h0040;
        len = 14'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!(icb_rsp_ready && cmd_cnt == 2) && lat < 40) begin
            tick();
            lat++;
        end
        check("a_reached_rsp", {63'd0, icb_rsp_ready}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("a_busy", {63'd0, busy}, 64'd0);
        check("a_cmd_valid", {63'd0, icb_cmd_valid}, 64'd0);
        check("a_rsp_ready", {63'd0, icb_rsp_ready}, 64'd0);
        check("a_checksum", {32'd0, checksum}, 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("a_no_more_cmds", 64'(cmd_cnt), 64'd2);
        check("a_idle", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
